// File: rtl/fw_upload_writer_pkg.sv
// Shared types and constants for the firmware-upload writer: FSM states,
// completion codes and CRC32 (IEEE, reflected) constants.
package fw_upload_writer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CRC   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CRC     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOR  = 32'hFFFF_FFFF;

endpackage

// File: rtl/fw_upload_writer_crc32_byte.sv
// One-byte step of the reflected CRC32: eight unrolled shift/XOR stages.
module fw_upload_writer_crc32_byte
  import fw_upload_writer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/fw_upload_writer.sv
// Firmware-upload writer: parses [LEN][PAYLOAD][CRC32] from a byte stream,
// packs the payload into little-endian words for program SRAM, reports status.
module fw_upload_writer
  import fw_upload_writer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] MAX_LEN        = 32'h0008_0000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code
);

  // Handshakes: a byte moves when in_valid & in_ready at a rising edge; a
  // write moves when mem_valid & mem_ready, and mem_* hold steady until then.

  state_t      state;
  logic [31:0] len;
  logic [31:0] cnt;
  logic [31:0] to_cnt;
  logic [31:0] crc_reg;
  logic [31:0] crc_next;
  logic [23:0] shift;
  logic [1:0]  fld_idx;
  logic [1:0]  lane;
  logic [31:0] fld_word;
  logic        accept;
  logic        counting;

  assign accept   = in_valid & in_ready;
  assign fld_word = {in_data, shift};
  assign lane     = cnt[1:0];
  assign busy     = (state != S_IDLE);
  assign counting = (state == S_LEN) || (state == S_DATA) || (state == S_CRC);

  fw_upload_writer_crc32_byte u_crc (
    .crc_in  (crc_reg),
    .data    (in_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      done      <= 1'b0;
      err_code  <= ERR_OK;
      len       <= '0;
      cnt       <= '0;
      to_cnt    <= '0;
      crc_reg   <= CRC32_INIT;
      shift     <= '0;
      fld_idx   <= '0;
    end else begin
      done <= 1'b0;

      // Inter-byte watchdog; WRITE is excluded so a slow memory never trips it.
      if (counting && !accept) begin
        if (to_cnt == TIMEOUT_CYCLES - 32'd1) begin
          to_cnt   <= '0;
          done     <= 1'b1;
          err_code <= ERR_TIMEOUT;
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 32'd1;
        end
      end else begin
        to_cnt <= '0;
      end

      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            shift     <= {in_data, shift[23:8]};
            fld_idx   <= 2'd1;
            err_code  <= ERR_OK;
            crc_reg   <= CRC32_INIT;
            cnt       <= '0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            state     <= S_LEN;
          end
        end

        S_LEN: begin
          if (accept) begin
            shift   <= {in_data, shift[23:8]};
            fld_idx <= fld_idx + 2'd1;
            if (fld_idx == 2'd3) begin
              len <= fld_word;
              if (fld_word > MAX_LEN) begin
                done     <= 1'b1;
                err_code <= ERR_LEN;
                state    <= S_IDLE;
              end else if (fld_word == 32'd0) begin
                state <= S_CRC;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            mem_wdata[{lane, 3'b000} +: 8] <= in_data;
            mem_wstrb[lane]                <= 1'b1;
            crc_reg <= crc_next;
            cnt     <= cnt + 32'd1;
            if (lane == 2'd3 || cnt + 32'd1 == len) begin
              mem_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_addr  <= mem_addr + 32'd4;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            in_ready  <= 1'b1;
            state     <= (cnt == len) ? S_CRC : S_DATA;
          end
        end

        S_CRC: begin
          if (accept) begin
            shift   <= {in_data, shift[23:8]};
            fld_idx <= fld_idx + 2'd1;
            if (fld_idx == 2'd3) begin
              done     <= 1'b1;
              err_code <= (fld_word == (crc_reg ^ CRC32_XOR)) ? ERR_OK : ERR_CRC;
              state    <= S_IDLE;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
